// File: rtl/serial_arb_pkg.sv
// Shared types and line levels for the serial line arbiter.
package serial_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scanning ptr+1 .. ptr+N_REQ puts the last winner at lowest priority.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_line_arbiter.sv
// Round-robin arbiter that frames one requester word at a time onto a serial line.
// Define SERIAL_ARB_PARITY_EN to append an even-parity bit after the data bits.
module serial_line_arbiter
    import serial_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = 8,
    parameter int GAP_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*WORD_W-1:0]   data_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      ser_out,
    output logic                      ser_valid,
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] pick_word;
    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              arb_slot;
`ifdef SERIAL_ARB_PARITY_EN
    logic              parity_q;
`endif

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_word = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) pick_word = data_i[k*WORD_W +: WORD_W];
        end
    end

    // Arbitration happens while idle and on the last gap cycle (back-to-back frames).
    assign arb_slot = (state == S_IDLE) || (state == S_GAP && gap_cnt == '0);

    // NOTE: the shift register is pure datapath, always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (arb_slot && pick_any) begin
            shift_q <= pick_word;
`ifdef SERIAL_ARB_PARITY_EN
            parity_q <= ^pick_word;
`endif
        end else if (state == S_START || state == S_DATA) begin
            shift_q <= shift_q << 1;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= IDX_W'(N_REQ - 1);
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ack_o     <= '0;
            grant_o   <= '0;
            ser_out   <= IDLE_LVL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack_o <= '0;
            if (arb_slot) begin
                if (pick_any) begin
                    state     <= S_START;
                    ptr       <= pick_idx;
                    ack_o     <= pick_grant;
                    grant_o   <= pick_grant;
                    ser_out   <= START_BIT;
                    ser_valid <= 1'b1;
                    busy      <= 1'b1;
                end else begin
                    state     <= S_IDLE;
                    grant_o   <= '0;
                    ser_out   <= IDLE_LVL;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            end else begin
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        ser_out <= shift_q[WORD_W-1];
                        bit_cnt <= CNT_W'(WORD_W - 1);
                    end
                    S_DATA: begin
                        if (bit_cnt != '0) begin
                            ser_out <= shift_q[WORD_W-1];
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
`ifdef SERIAL_ARB_PARITY_EN
                            state   <= S_PARITY;
                            ser_out <= parity_q;
`else
                            state     <= S_GAP;
                            ser_out   <= IDLE_LVL;
                            ser_valid <= 1'b0;
                            gap_cnt   <= GAP_W'(GAP_CYC - 1);
`endif
                        end
                    end
                    S_PARITY: begin
                        state     <= S_GAP;
                        ser_out   <= IDLE_LVL;
                        ser_valid <= 1'b0;
                        gap_cnt   <= GAP_W'(GAP_CYC - 1);
                    end
                    S_GAP:   gap_cnt <= gap_cnt - 1'b1;
                    default: state   <= S_IDLE;
                endcase
            end
        end
    end

endmodule
